// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared array geometry, operand element and feeder types
//
// Purpose: array size, element layout and the edge-feeder state/length types
// shared by the operand feeders and the PE array.
// Ports: none (package).
package common_pkg;

  localparam int SYS_ARRAY_SIZE = 2;
  localparam int DATA_WIDTH     = 8;
  localparam int K_WIDTH        = 16;

  typedef logic [K_WIDTH-1:0] klen_t;

  // One operand element as seen by a PE: payload plus end-of-pass marker.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } matrix_data_t;

  typedef matrix_data_t [SYS_ARRAY_SIZE-1:0] edge_feed_t;

  typedef enum logic [1:0] {
    FD_IDLE  = 2'd0,
    FD_FEED  = 2'd1,
    FD_FLUSH = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth shift register used for diagonal skew
//
// Purpose: delays one lane's element stream by DEPTH cycles.
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high reset, clears every stage
//   d_i    in   element entering the line
//   q_o    out  element leaving the line (registered)
module skew_delay_line
  import common_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = matrix_data_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     d_i,
  output T     q_o
);

  T stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// rtl/operand_skew_feeder.sv - skewed operand feeder for one systolic array edge
//
// Purpose: accepts one K-element column vector per handshake and drives lane i
// of the array edge with that vector's element delayed i+1 cycles, tagging the
// final vector of a pass with last=1.
// Optional feature: FEEDER_STALL_CNT_EN adds stall_cnt_o (FEED cycles without
// upstream valid, cleared by an accepted start, saturating).
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   start_i      in   begin a pass (sampled in IDLE only)
//   k_len_i      in   vectors in the pass, sampled with start_i
//   vec_valid_i  in   upstream vector valid
//   vec_ready_o  out  high while in FEED
//   vec_data_i   in   lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pe_data_o    out  skewed {data,last} per lane
//   busy_o       out  state != IDLE
//   done_o       out  one-cycle pass-end pulse
//   stall_cnt_o  out  (FEEDER_STALL_CNT_EN only) stall cycle count
module operand_skew_feeder
  import common_pkg::*;
#(
  parameter int N       = SYS_ARRAY_SIZE,
  parameter int K_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  input  logic                    vec_valid_i,
  output logic                    vec_ready_o,
  input  logic [N*DATA_WIDTH-1:0] vec_data_i,
  output matrix_data_t [N-1:0]    pe_data_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam logic [1:0] S_IDLE  = FD_IDLE;
  localparam logic [1:0] S_FEED  = FD_FEED;
  localparam logic [1:0] S_FLUSH = FD_FLUSH;

  localparam int                 FW         = (N > 2) ? $clog2(N) : 1;
  localparam logic [FW-1:0]      FLUSH_LAST = FW'((N > 1) ? N - 2 : 0);
  localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

  logic [1:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept;
  logic last_vec;

  // ready_q is only ever set while in FEED, so accept implies FEED.
  assign accept   = vec_valid_i & ready_q;
  // k_len_q >= 1 whenever FEED is entered, so K-1 never underflows here.
  assign last_vec = (k_cnt_q == (k_len_q - K_ONE));

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    k_len_d     = k_len_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_cnt_d = '0;
          k_len_d = k_len_i;
          if (k_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (accept) begin
          // K <= 2^K_WIDTH-1, so this stops at K and cannot wrap.
          k_cnt_d = k_cnt_q + K_ONE;
          if (last_vec) begin
            flush_cnt_d = '0;
            if (N == 1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        // Final accept at t: FLUSH spans t+1..t+N-1, done_o lands at t+N,
        // the same cycle lane N-1 shows last=1.
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_FEED);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      k_cnt_q     <= '0;
      k_len_q     <= '0;
      flush_cnt_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      k_len_q     <= k_len_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // Every non-accept cycle injects {0,0}: stall bubbles in FEED, drain in
  // FLUSH/IDLE. Matching bubbles on the twin feeder multiply to zero.
  for (genvar i = 0; i < N; i++) begin : g_lane
    matrix_data_t lane_in;
    assign lane_in.data = accept ? vec_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign lane_in.last = accept & last_vec;

    skew_delay_line #(
      .DEPTH (i + 1),
      .T     (matrix_data_t)
    ) u_skew (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (lane_in),
      .q_o   (pe_data_o[i])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start_i) begin
      stall_cnt_d = '0;
    end else if (state_q == S_FEED && !vec_valid_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb/tb_operand_skew_feeder.sv - self-checking bench for operand_skew_feeder
module tb_operand_skew_feeder;
  import common_pkg::*;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int MAXC = 4000;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 start_i = 1'b0;
  logic [15:0]          k_len_i = '0;
  logic                 vec_valid_i = 1'b0;
  logic                 vec_ready_o;
  logic [N*DW-1:0]      vec_data_i = '0;
  matrix_data_t [N-1:0] pe_data_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]          stall_cnt_o;
`endif

  operand_skew_feeder #(.N(N), .K_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .k_len_i     (k_len_i),
    .vec_valid_i (vec_valid_i),
    .vec_ready_o (vec_ready_o),
    .vec_data_i  (vec_data_i),
    .pe_data_o   (pe_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 0;

  // Expected-output schedule indexed by cycle, filled in at accept time.
  logic [DW:0] exp_pe [N][0:MAXC+N+2];
  logic        exp_done [0:MAXC+N+2];

  // Pass-level reference state.
  bit          m_feed = 0;
  int          m_idle_from = 0;
  int          m_k = 0;
  int          m_cnt = 0;
  logic [31:0] m_stall = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic [15:0] k, input logic v,
                      input logic [N*DW-1:0] d, input logic r);
    bit nf;
    bit lst;
    rst_i = r; start_i = s; k_len_i = k; vec_valid_i = v; vec_data_i = d;
    @(negedge clk);
    if (chk_on) begin
      chk("ready", 32'(vec_ready_o), 32'(m_feed));
      chk("busy", 32'(busy_o), 32'(m_feed || (cyc < m_idle_from)));
      chk("done", 32'(done_o), 32'(exp_done[cyc]));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("lane%0d", i), 32'(pe_data_o[i]), 32'(exp_pe[i][cyc]));
      end
`ifdef FEEDER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt_o, m_stall);
`endif
    end
    if (r) begin
      for (int j = cyc + 1; j <= MAXC + N + 2; j++) begin
        exp_done[j] = 1'b0;
        for (int i = 0; i < N; i++) exp_pe[i][j] = '0;
      end
      m_feed = 0; m_idle_from = cyc + 1; m_cnt = 0; m_stall = '0;
      chk_on = 1;
    end else begin
      nf = m_feed;
      if (m_feed && v) begin
        lst = (m_cnt == m_k - 1);
        for (int i = 0; i < N; i++) exp_pe[i][cyc + 1 + i] = {d[i*DW +: DW], lst};
        m_cnt++;
        if (lst) begin
          nf = 0;
          exp_done[cyc + N] = 1'b1;
          m_idle_from = cyc + N;
        end
      end
      if (m_feed && !v && m_stall != '1) m_stall++;
      if (!m_feed && cyc >= m_idle_from && s) begin
        m_stall = '0;
        if (k == 0) exp_done[cyc + 1] = 1'b1;
        else begin
          nf = 1; m_k = int'(k); m_cnt = 0;
        end
      end
      m_feed = nf;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  initial begin
    for (int j = 0; j <= MAXC + N + 2; j++) begin
      exp_done[j] = 1'b0;
      for (int i = 0; i < N; i++) exp_pe[i][j] = '0;
    end
    #1;
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    idle(1);
    // K=3, no stall
    step(1, 3, 0, '0, 0);
    step(0, 0, 1, 16'h0201, 0);
    step(0, 0, 1, 16'h0403, 0);
    step(0, 0, 1, 16'h0605, 0);
    idle(4);
    // K=3, one stall after the first vector
    step(1, 3, 0, '0, 0);
    step(0, 0, 1, 16'h0201, 0);
    step(0, 0, 0, 16'h0403, 0);
    step(0, 0, 1, 16'h0403, 0);
    step(0, 0, 1, 16'h0605, 0);
    idle(4);
    // K=1 and K=0
    step(1, 1, 0, '0, 0);
    step(0, 0, 1, 16'h0709, 0);
    idle(3);
    step(1, 0, 1, 16'h5555, 0);
    idle(3);
    // start mid-FEED is ignored
    step(1, 3, 0, '0, 0);
    step(0, 0, 1, 16'h1111, 0);
    step(1, 9, 1, 16'h2222, 0);
    step(0, 0, 1, 16'h3333, 0);
    idle(4);
    // reset at the second accept
    step(1, 4, 0, '0, 0);
    step(0, 0, 1, 16'h1111, 0);
    step(0, 0, 1, 16'h2222, 1);
    idle(5);
    // back-to-back: second start in the done cycle
    step(1, 2, 0, '0, 0);
    step(0, 0, 1, 16'h0a0b, 0);
    step(0, 0, 1, 16'h0c0d, 0);
    idle(1);
    step(1, 2, 0, '0, 0);
    step(0, 0, 1, 16'h0e0f, 0);
    step(0, 0, 1, 16'h1213, 0);
    idle(4);
    // K=4 with three stalls, then a fresh start
    step(1, 4, 0, '0, 0);
    step(0, 0, 1, 16'h0101, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 16'h0202, 0);
    step(0, 0, 1, 16'h0303, 0);
    step(0, 0, 1, 16'h0404, 0);
    idle(3);
    step(1, 1, 0, '0, 0);
    step(0, 0, 1, 16'h0505, 0);
    idle(3);
    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      step(($urandom % 4) == 0, 16'($urandom % 6), ($urandom % 4) != 0,
           16'($urandom), ($urandom % 300) == 0);
    end
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
